// File: rtl/bcd_count_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bcd_ctrl_pkg
// Shared definitions for the two-digit BCD counter sequencer:
//   - state_t  : sequencer state encoding (IDLE, LOAD, COUNT, PAUSE, DONE)
//   - BCD_MAX  : largest value two BCD digits can show (99)
//   - clampBcd : limits a requested step count to BCD_MAX
// No ports (package).
// ----------------------------------------------------------------------------
package bcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COUNT = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [6:0] BCD_MAX = 7'd99;

    // Requests above 99 cannot be shown on two digits, so they saturate.
    function automatic logic [6:0] clampBcd(input logic [6:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_btn_edge.sv
// ----------------------------------------------------------------------------
// btn_edge
// One-bit rising-edge detector for a button level already synchronous to clk.
// A held button produces a single one-cycle event.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (history cleared to 0)
//   i_btn  : button level
//   o_rise : high for the cycle in which i_btn is 1 and was 0 last cycle
// ----------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic r_q;

    // Remember last cycle's level so a rise can be recognised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_q;

endmodule

// File: rtl/bcd_count_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_count_ctrl
// Sequencer for the two-digit BCD up-counter. Converts start/pause/clear
// button levels into a run level and a prescaled one-cycle step strobe,
// tracks the steps still to issue and flags completion.
// Parameters:
//   TICK_DIV : clk cycles per step while counting (1..65535)
//   PRESC_W  : prescaler width, derived from TICK_DIV (do not override)
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   max_count : requested step count, sampled only in LOAD
//   start     : start/resume button level
//   pause     : pause-toggle button level
//   clear     : abort/clear button level (level-sensitive)
//   run       : counter run level (0 holds the digits at 00)
//   step      : one-cycle count-enable strobe
//   remaining : steps still to issue
//   busy      : high in COUNT or PAUSE
//   done      : high in DONE
// Optional feature: define BCD_COUNT_CTRL_AUTO_RESTART_EN to make DONE hold
// for TICK_DIV cycles and then reload automatically.
// ----------------------------------------------------------------------------
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int PRESC_W  = $clog2(TICK_DIV + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] max_count,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic       run,
    output logic       step,
    output logic [6:0] remaining,
    output logic       busy,
    output logic       done
);

    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICK_DIV - 1);

    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [6:0]         r_remaining;

    state_t             w_next;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [6:0]         w_rem_nxt;
    logic [6:0]         w_clamped;
    logic               w_wrap;
    logic               w_step;
    logic               w_start_rise;
    logic               w_pause_rise;

    btn_edge u_start_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (start),
        .o_rise (w_start_rise)
    );

    btn_edge u_pause_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (pause),
        .o_rise (w_pause_rise)
    );

    assign w_clamped = clampBcd(max_count);
    assign w_wrap    = (r_presc == PRESC_TERM);

    // State, prescaler and remaining-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_remaining <= 7'd0;
        end else begin
            r_state     <= w_next;
            r_presc     <= w_presc_nxt;
            r_remaining <= w_rem_nxt;
        end
    end

    // Next-state logic. clear outranks every other event and also masks the
    // step of a prescaler wrap in the same cycle. A wrap that issues the last
    // step goes to DONE even if pause rises together with it, so a paused
    // sequence always has at least one step left.
    always_comb begin
        w_next      = r_state;
        w_presc_nxt = r_presc;
        w_rem_nxt   = r_remaining;
        w_step      = 1'b0;

        if (clear) begin
            w_next      = IDLE;
            w_presc_nxt = '0;
            w_rem_nxt   = 7'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_presc_nxt = '0;
                    w_rem_nxt   = 7'd0;
                    if (w_start_rise) begin
                        w_next = LOAD;
                    end
                end
                LOAD: begin
                    w_presc_nxt = '0;
                    w_rem_nxt   = w_clamped;
                    w_next      = (w_clamped != 7'd0) ? COUNT : DONE;
                end
                COUNT: begin
                    if (w_wrap) begin
                        w_step      = 1'b1;
                        w_presc_nxt = '0;
                        w_rem_nxt   = r_remaining - 7'd1;
                        if (r_remaining == 7'd1) begin
                            w_next = DONE;
                        end else if (w_pause_rise) begin
                            w_next = PAUSE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PRESC_W'(1);
                        if (w_pause_rise) begin
                            w_next = PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (w_start_rise || w_pause_rise) begin
                        w_next = COUNT;
                    end
                end
                DONE: begin
                    if (w_start_rise) begin
                        w_next = LOAD;
                    end else begin
`ifdef BCD_COUNT_CTRL_AUTO_RESTART_EN
                        // Prescaler enters DONE at 0, so DONE lasts TICK_DIV cycles.
                        if (w_wrap) begin
                            w_next      = LOAD;
                            w_presc_nxt = '0;
                        end else begin
                            w_presc_nxt = r_presc + PRESC_W'(1);
                        end
`else
                        w_next = DONE;
`endif
                    end
                end
                default: begin
                    w_next      = IDLE;
                    w_presc_nxt = '0;
                    w_rem_nxt   = 7'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state so they drop the moment
    // rst_n is asserted.
    assign step      = w_step;
    assign run       = (r_state == COUNT) || (r_state == PAUSE) || (r_state == DONE);
    assign busy      = (r_state == COUNT) || (r_state == PAUSE);
    assign done      = (r_state == DONE);
    assign remaining = r_remaining;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bcd_count_ctrl
// Self-checking bench for bcd_count_ctrl with TICK_DIV=4: a vector table,
// hand-written corner sequences and a randomized run against a reference
// model of the sequencing rules.
// ----------------------------------------------------------------------------
module tb_bcd_count_ctrl;

    localparam int TICK_DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_COUNT = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] max_count;
    logic       start;
    logic       pause;
    logic       clear;
    logic       run;
    logic       step;
    logic [6:0] remaining;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    int mMode;
    int mPhase;
    int mLeft;
    bit mPrevStart;
    bit mPrevPause;

    int obsRun;
    int obsStep;
    int obsRem;
    int obsDone;

    typedef struct {
        bit         s;
        bit         p;
        bit         c;
        logic [6:0] m;
        int         eRun;
        int         eStep;
        int         eRem;
        int         eBusy;
        int         eDone;
    } vec_t;

    vec_t tbl [13];

    bcd_count_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .max_count (max_count),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .run       (run),
        .step      (step),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cycleNo);
        end
    endtask

    // Drive the button levels and max_count for the coming clock edge.
    task automatic applyStimulus(input bit s, input bit p, input bit c, input logic [6:0] m);
        start     = s;
        pause     = p;
        clear     = c;
        max_count = m;
    endtask

    task automatic modelReset();
        mMode      = M_IDLE;
        mPhase     = 0;
        mLeft      = 0;
        mPrevStart = 1'b0;
        mPrevPause = 1'b0;
    endtask

    // Reference model: advance one clock using the sequencing rules.
    task automatic modelAdvance();
        bit sr;
        bit pr;
        int req;
        sr = start && !mPrevStart;
        pr = pause && !mPrevPause;
        mPrevStart = start;
        mPrevPause = pause;
        if (clear) begin
            mMode  = M_IDLE;
            mLeft  = 0;
            mPhase = 0;
        end else begin
            case (mMode)
                M_IDLE: if (sr) mMode = M_LOAD;
                M_LOAD: begin
                    req    = int'(max_count);
                    mLeft  = (req > 99) ? 99 : req;
                    mPhase = 0;
                    mMode  = (mLeft != 0) ? M_COUNT : M_DONE;
                end
                M_COUNT: begin
                    if (mPhase == TICK_DIV - 1) begin
                        mPhase = 0;
                        mLeft  = mLeft - 1;
                        if (mLeft == 0) mMode = M_DONE;
                        else if (pr) mMode = M_PAUSE;
                    end else begin
                        mPhase = mPhase + 1;
                        if (pr) mMode = M_PAUSE;
                    end
                end
                M_PAUSE: if (sr || pr) mMode = M_COUNT;
                M_DONE: begin
                    if (sr) begin
                        mMode = M_LOAD;
                    end else begin
`ifdef BCD_COUNT_CTRL_AUTO_RESTART_EN
                        if (mPhase == TICK_DIV - 1) begin
                            mMode  = M_LOAD;
                            mPhase = 0;
                        end else begin
                            mPhase = mPhase + 1;
                        end
`endif
                    end
                end
                default: mMode = M_IDLE;
            endcase
        end
    endtask

    // One clock against the model: drive, check, clock, advance the model.
    task automatic doCycle(input bit s, input bit p, input bit c, input logic [6:0] m);
        int eRun;
        int eStep;
        applyStimulus(s, p, c, m);
        #1;
        eRun  = (mMode == M_COUNT || mMode == M_PAUSE || mMode == M_DONE) ? 1 : 0;
        eStep = (mMode == M_COUNT && mPhase == TICK_DIV - 1 && !c) ? 1 : 0;
        checkOutput("run", int'(run), eRun);
        checkOutput("step", int'(step), eStep);
        checkOutput("remaining", int'(remaining), mLeft);
        checkOutput("busy", int'(busy), (mMode == M_COUNT || mMode == M_PAUSE) ? 1 : 0);
        checkOutput("done", int'(done), (mMode == M_DONE) ? 1 : 0);
        obsRun  = int'(run);
        obsStep = int'(step);
        obsRem  = int'(remaining);
        obsDone = int'(done);
        @(posedge clk);
        modelAdvance();
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic resetAll();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int firstRun;
        int nSteps;
        int stepAt [$];
        int firstStep;
        int doneCycles;
        bit rs;
        bit rp;

        tbl[0]  = '{1, 0, 0, 7'd2, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 7'd2, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 7'd2, 1, 0, 2, 1, 0};
        tbl[3]  = '{0, 0, 0, 7'd2, 1, 0, 2, 1, 0};
        tbl[4]  = '{0, 0, 0, 7'd2, 1, 0, 2, 1, 0};
        tbl[5]  = '{0, 0, 0, 7'd2, 1, 1, 2, 1, 0};
        tbl[6]  = '{0, 0, 0, 7'd2, 1, 0, 1, 1, 0};
        tbl[7]  = '{0, 0, 0, 7'd2, 1, 0, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 7'd2, 1, 0, 1, 1, 0};
        tbl[9]  = '{0, 0, 0, 7'd2, 1, 1, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 7'd2, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 1, 7'd2, 1, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 7'd2, 0, 0, 0, 0, 0};

        // Reset state while rst_n is held low.
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        rst_n = 1'b0;
        #3;
        checkOutput("reset run", int'(run), 0);
        checkOutput("reset step", int'(step), 0);
        checkOutput("reset remaining", int'(remaining), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);

        // Vector table: two-step run, completion and clear.
        resetAll();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].m);
            #1;
            checkOutput($sformatf("tbl%0d run", i), int'(run), tbl[i].eRun);
            checkOutput($sformatf("tbl%0d step", i), int'(step), tbl[i].eStep);
            checkOutput($sformatf("tbl%0d remaining", i), int'(remaining), tbl[i].eRem);
            checkOutput($sformatf("tbl%0d busy", i), int'(busy), tbl[i].eBusy);
            checkOutput($sformatf("tbl%0d done", i), int'(done), tbl[i].eDone);
            @(posedge clk);
            modelAdvance();
            cycleNo++;
            @(negedge clk);
        end

        // Five steps spaced TICK_DIV apart, run rising two cycles after start.
        resetAll();
        firstRun = -1;
        stepAt.delete();
        for (int i = 0; i < 40; i++) begin
            doCycle(i == 0, 1'b0, 1'b0, 7'd5);
            if (obsRun == 1 && firstRun < 0) firstRun = i;
            if (obsStep == 1) stepAt.push_back(i);
        end
        checkOutput("A first run cycle", firstRun, 2);
        checkOutput("A step count", stepAt.size(), 5);
        for (int k = 0; k < stepAt.size(); k++) begin
            checkOutput($sformatf("A step %0d cycle", k), stepAt[k], 1 + TICK_DIV + TICK_DIV * k);
        end
`ifndef BCD_COUNT_CTRL_AUTO_RESTART_EN
        checkOutput("A done held", int'(done), 1);
        checkOutput("A run held", int'(run), 1);
`endif

        // Oversized request clamps to 99 steps.
        resetAll();
        doCycle(1'b1, 1'b0, 1'b0, 7'd120);
        doCycle(1'b0, 1'b0, 1'b0, 7'd120);
        checkOutput("B load clamp", int'(remaining), 99);
        nSteps = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            doCycle(1'b0, 1'b0, 1'b0, 7'($urandom_range(0, 127)));
            nSteps += obsStep;
        end
        checkOutput("B done reached", int'(done), 1);
        checkOutput("B step count", nSteps, 99);

        // Zero request: LOAD then DONE, no steps.
        resetAll();
        nSteps = 0;
        doCycle(1'b1, 1'b0, 1'b0, 7'd0);
        nSteps += obsStep;
        doCycle(1'b0, 1'b0, 1'b0, 7'd0);
        nSteps += obsStep;
        checkOutput("C not done at N+1", obsDone, 0);
        #1;
        checkOutput("C done at N+2", int'(done), 1);
        checkOutput("C step count", nSteps, 0);

        // Pause after the second step, resume with start.
        resetAll();
        nSteps = 0;
        doCycle(1'b1, 1'b0, 1'b0, 7'd5);
        for (int i = 0; i < 50 && nSteps < 2; i++) begin
            doCycle(1'b0, 1'b0, 1'b0, 7'd5);
            nSteps += obsStep;
        end
        checkOutput("D reached two steps", nSteps, 2);
        nSteps = 0;
        for (int i = 0; i < 21; i++) begin
            doCycle(1'b0, 1'b1, 1'b0, 7'd5);
            nSteps += obsStep;
        end
        checkOutput("D steps during pause", nSteps, 0);
        checkOutput("D remaining during pause", obsRem, 3);
        checkOutput("D busy during pause", int'(busy), 1);
        doCycle(1'b1, 1'b0, 1'b0, 7'd5);
        firstStep = -1;
        for (int j = 1; j <= 10 && firstStep < 0; j++) begin
            doCycle(1'b0, 1'b0, 1'b0, 7'd5);
            if (obsStep == 1) firstStep = j;
        end
        checkOutput("D resume to third step", firstStep, 3);

        // clear with start high on a prescaler wrap.
        resetAll();
        doCycle(1'b1, 1'b0, 1'b0, 7'd5);
        for (int i = 1; i < 5; i++) doCycle(1'b0, 1'b0, 1'b0, 7'd5);
        doCycle(1'b1, 1'b0, 1'b1, 7'd5);
        checkOutput("E step suppressed", obsStep, 0);
        doCycle(1'b1, 1'b0, 1'b0, 7'd5);
        checkOutput("E run after clear", obsRun, 0);
        checkOutput("E remaining after clear", obsRem, 0);
        doCycle(1'b1, 1'b0, 1'b0, 7'd5);
        checkOutput("E held start stays idle", obsRun, 0);

        // Asynchronous reset in the middle of COUNT.
        resetAll();
        doCycle(1'b1, 1'b0, 1'b0, 7'd9);
        for (int i = 0; i < 4; i++) doCycle(1'b0, 1'b0, 1'b0, 7'd9);
        checkOutput("F run before reset", int'(run), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("F async run", int'(run), 0);
        checkOutput("F async step", int'(step), 0);
        checkOutput("F async remaining", int'(remaining), 0);
        checkOutput("F async busy", int'(busy), 0);
        checkOutput("F async done", int'(done), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // DONE duration: TICK_DIV cycles with auto-restart, otherwise held.
        resetAll();
        doneCycles = 0;
        for (int i = 0; i < 14; i++) begin
            doCycle(i == 0, 1'b0, 1'b0, 7'd1);
            doneCycles += obsDone;
            if (i == 10) begin
`ifdef BCD_COUNT_CTRL_AUTO_RESTART_EN
                checkOutput("G reload run", obsRun, 0);
`else
                checkOutput("G held run", obsRun, 1);
`endif
            end
        end
`ifdef BCD_COUNT_CTRL_AUTO_RESTART_EN
        checkOutput("G done cycles", doneCycles, TICK_DIV);
`else
        checkOutput("G done cycles", doneCycles, 8);
`endif

        // Randomized button activity against the model.
        resetAll();
        rs = 1'b0;
        rp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            if ($urandom_range(0, 9) == 0) rp = ~rp;
            doCycle(rs, rp, $urandom_range(0, 39) == 0, 7'($urandom_range(0, 127)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
